muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL expose the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL expose the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL expose the port start, input, 1 bit: request a new M-extension operation; sampled only in IDLE.
REQ-004 The block SHALL expose the port flush, input, 1 bit: pipeline kill; aborts any operation in progress.
REQ-005 The block SHALL expose the port funct3, input, 3 bits, with this encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL expose the port op_a, input, 32 bits: rs1 operand (dividend or multiplicand).
REQ-007 The block SHALL expose the port op_b, input, 32 bits: rs2 operand (divisor or multiplier).
REQ-008 The block SHALL expose the port busy, output, 1 bit: an operation is in flight.
REQ-009 The block SHALL expose the port stall, output, 1 bit: freezes the IF/ID/EX stages; equals (start & IDLE & ~flush) | busy.
REQ-010 The block SHALL expose the port done, output, 1 bit: a one-cycle pulse; result is valid in that cycle.
REQ-011 The block SHALL expose the port result, output, 32 bits: the final value; it holds until the next accepted start.

Function
REQ-012 The block SHALL have exactly the states IDLE, MUL, DIV and DONE, with a 2-bit state register.
REQ-013 From IDLE, start=1 and flush=0 SHALL latch funct3 and both operands, clear the 6-bit iteration counter, and move to MUL for funct3[2]=0 or DIV for funct3[2]=1.
REQ-014 A start received while not in IDLE SHALL be ignored; no queuing is performed.
REQ-015 MUL SHALL perform 32 shift-add iterations on operand magnitudes into a 64-bit accumulator, one bit per cycle, and then go to DONE.
REQ-016 DIV SHALL perform 32 restoring shift-subtract iterations on magnitudes, producing a 32-bit quotient and remainder, and then go to DONE.
REQ-017 Signedness SHALL follow funct3: MULH uses both operands signed; MULHSU uses op_a signed and op_b unsigned; DIV and REM are signed; MULHU, DIVU and REMU are unsigned. MUL is sign-agnostic (low 32 bits).
REQ-018 Result sign correction SHALL be applied on the MUL/DIV to DONE transition: the product is negated when the operand signs differ; the quotient is negated when the signs differ; the remainder takes the sign of the dividend.
REQ-019 result SHALL be selected as: MUL gives product[31:0]; MULH, MULHSU and MULHU give product[63:32]; DIV and DIVU give the quotient; REM and REMU give the remainder.
REQ-020 Normal latency SHALL be: start sampled at edge N, busy=1 for cycles N+1..N+32, done=1 and result valid in cycle N+33, then IDLE at N+34.
REQ-021 Fast path for divide by zero (op_b=0) SHALL go IDLE to DONE directly with done in cycle N+1: the quotient is 0xFFFFFFFF and the remainder is op_a.
REQ-022 Fast path for signed overflow (DIV or REM with op_a=0x80000000 and op_b=0xFFFFFFFF) SHALL go directly to DONE: the quotient is 0x80000000 and the remainder is 0.
REQ-023 In DONE, busy SHALL be 0 and stall SHALL be 0; DONE always returns to IDLE after one cycle.
REQ-024 A start that arrives in the DONE cycle SHALL be ignored, since the EX stage consumes result in that cycle.
REQ-025 flush=1 in MUL or DIV SHALL force IDLE on the next edge with no done pulse, and result SHALL keep its previous value.
REQ-026 flush=1 in DONE SHALL have no effect on that done pulse.
REQ-027 flush and start asserted together in IDLE SHALL be treated as flush: the start is not accepted.
REQ-028 The iteration counter SHALL saturate at 32 with no wrap-around and SHALL be cleared on every accept.

Reset
REQ-029 Asserting rst SHALL immediately, without waiting for a clock edge, force the state to IDLE and set busy=0, done=0, stall=0, result=0, counter=0 and accumulator=0.
REQ-030 Asserting rst mid-operation SHALL discard the operation; after release, the block SHALL accept start on the first rising edge.

Verification
REQ-031 The bench SHALL drive MUL with op_a=7 and op_b=6, and check result=42 with done exactly 33 cycles after start.
REQ-032 The bench SHALL drive MULH with op_a=0xFFFFFFFF (-1) and op_b=0xFFFFFFFF, and check result=0x00000000; it SHALL drive MULHU with the same operands and check result=0xFFFFFFFE.
REQ-033 The bench SHALL drive DIV with op_a=-7 and op_b=2, and check result=0xFFFFFFFD (-3); it SHALL drive REM with the same operands and check result=0xFFFFFFFF (-1).
REQ-034 The bench SHALL drive DIVU with op_b=0 and REMU with op_a=0x1234 and op_b=0, and check results 0xFFFFFFFF and 0x1234 respectively, each with done at N+1.
REQ-035 The bench SHALL drive DIV with op_a=0x80000000 and op_b=0xFFFFFFFF, and check result=0x80000000 with done at N+1.
REQ-036 The bench SHALL start DIVU, pulse flush at cycle N+10, and check: no done; busy=0 at N+11; result unchanged; and a new start at N+12 is accepted. It SHALL also assert rst at N+5 of a MUL and check that all outputs are 0 before the next edge.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide on operand magnitudes, with divide-by-zero and overflow fast paths.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [2:0]  fn;
    logic        neg_a, neg_b;
    logic [31:0] mag;
    logic [63:0] acc;

    logic        a_sgn, b_sgn, in_neg_a, in_neg_b;
    logic [31:0] in_mag_a, in_mag_b;
    logic        accept, div_zero, div_ovf;

    always_comb begin
        a_sgn    = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
        b_sgn    = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
        in_neg_a = a_sgn & op_a[31];
        in_neg_b = b_sgn & op_b[31];
        in_mag_a = in_neg_a ? (32'd0 - op_a) : op_a;
        in_mag_b = in_neg_b ? (32'd0 - op_b) : op_b;
        accept   = (state == IDLE) & start & ~flush;
        div_zero = funct3[2] & (op_b == 32'd0);
        div_ovf  = funct3[2] & ~funct3[0] & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
    end

    // acc holds {hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    logic [32:0] mul_sum, rem_sh, rem_diff;
    logic        q_bit;
    logic [31:0] rem_new;
    logic [63:0] step_next, prod;
    logic [31:0] quo, rem, final_result;

    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag} : 33'd0);
        rem_sh   = {acc[63:32], acc[31]};
        rem_diff = rem_sh - {1'b0, mag};
        q_bit    = (rem_sh >= {1'b0, mag});
        rem_new  = q_bit ? rem_diff[31:0] : rem_sh[31:0];
        if (state == MUL)
            step_next = {mul_sum, acc[31:1]};
        else
            step_next = {rem_new, acc[30:0], q_bit};

        prod = (neg_a ^ neg_b) ? (64'd0 - step_next) : step_next;
        quo  = (neg_a ^ neg_b) ? (32'd0 - step_next[31:0]) : step_next[31:0];
        rem  = neg_a ? (32'd0 - step_next[63:32]) : step_next[63:32];

        case (fn)
            3'b000:                 final_result = prod[31:0];
            3'b001, 3'b010, 3'b011: final_result = prod[63:32];
            3'b100, 3'b101:         final_result = quo;
            default:                final_result = rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            fn     <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            mag    <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        fn    <= funct3;
                        neg_a <= in_neg_a;
                        neg_b <= in_neg_b;
                        cnt   <= '0;
                        if (div_zero) begin
                            result <= funct3[1] ? op_a : '1;
                            state  <= DONE;
                        end else if (div_ovf) begin
                            result <= funct3[1] ? '0 : 32'h8000_0000;
                            state  <= DONE;
                        end else if (funct3[2]) begin
                            mag   <= in_mag_b;
                            acc   <= {32'd0, in_mag_a};
                            state <= DIV;
                        end else begin
                            mag   <= in_mag_a;
                            acc   <= {32'd0, in_mag_b};
                            state <= MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= step_next;
                        if (cnt != 6'd32)
                            cnt <= cnt + 6'd1;
                        // The 32nd step's result is sign-corrected on the way into DONE
                        if (cnt == 6'd31) begin
                            result <= final_result;
                            state  <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state == MUL) | (state == DIV);
    assign done  = (state == DONE);
    assign stall = ~rst & ((start & (state == IDLE) & ~flush) | busy);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: arithmetic reference model with a
// per-cycle output checker, plus directed vectors with hand-computed results.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, stall, done;
    logic [31:0] result;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [2:0] f, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint      p;
        logic [63:0] up;
        int          sa, sb;
        logic        ovf;
        logic [31:0] r;
        sa  = $signed(a);
        sb  = $signed(b);
        up  = {32'd0, a} * {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 0;
        r   = '0;
        case (f)
            3'd0: r = up[31:0];
            3'd1: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'd0, b}); r = p[63:32]; end
            3'd3: r = up[63:32];
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Cycle model: busy for 32 cycles after an accept, then one done cycle
    int          left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_result = '0;
    logic [31:0] pend = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            left     <= 0;
            m_done   <= 1'b0;
            m_result <= '0;
            pend     <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (left > 0) begin
            if (flush) begin
                left <= 0;
            end else begin
                left <= left - 1;
                if (left == 1) begin
                    m_done   <= 1'b1;
                    m_result <= pend;
                end
            end
        end else if (start && !flush) begin
            if (is_fast(funct3, op_a, op_b)) begin
                m_done   <= 1'b1;
                m_result <= model_result(funct3, op_a, op_b);
            end else begin
                left <= 32;
                pend <= model_result(funct3, op_a, op_b);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", 32'(busy), 32'(left > 0));
            check("done", 32'(done), 32'(m_done));
            check("stall", 32'(stall), 32'((start && left == 0 && !m_done && !flush) || left > 0));
            check("result", result, m_result);
        end
    end

    // Called at #1 after edge N; measures the cycle index of done relative to N
    task automatic wait_done(input string name, input logic [31:0] exp_r, input int exp_lat);
        int lat;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, result, exp_r);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int exp_lat, input string name);
        @(posedge clk);
        #1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(name, exp_r, exp_lat);
    endtask

    initial begin
        logic [31:0] prev;
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] prev;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;

        check("model mulhsu", model_result(3'd2, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        check("model rem", model_result(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("model div", model_result(3'd4, 32'h0000_0007, 32'hFFFF_FFFE), 32'hFFFF_FFFD);

        run_op(3'd0, 32'd7,          32'd6,          32'd42,         33, "mul_7x6");
        run_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  33, "mulh_m1");
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33, "mulhu_max");
        run_op(3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, "div_m7_2");
        run_op(3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, "rem_m7_2");
        run_op(3'd5, 32'h0000_0055,  32'd0,          32'hFFFF_FFFF,  1,  "divu_by0");
        run_op(3'd7, 32'h0000_1234,  32'd0,          32'h0000_1234,  1,  "remu_by0");
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  "div_ovf");
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  1,  "rem_ovf");
        run_op(3'd6, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1,  "rem_by0");
        run_op(3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33, "mulhsu_m1x2");
        run_op(3'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33, "mulhsu_min_umax");
        run_op(3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  33, "mulh_min_sq");
        run_op(3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  33, "mul_low");
        run_op(3'd4, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33, "div_7_m2");
        run_op(3'd6, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001,  33, "rem_7_m2");
        run_op(3'd5, 32'd100,        32'd7,          32'd14,         33, "divu_100_7");
        run_op(3'd7, 32'd100,        32'd7,          32'd2,          33, "remu_100_7");
        run_op(3'd5, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33, "divu_by1");

        // Start during the done cycle is dropped
        funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_in_done busy", 32'(busy), 32'd0);

        // Start with flush in IDLE is not accepted
        @(posedge clk);
        #1;
        start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("start_flush busy", 32'(busy), 32'd0);
        check("start_flush done", 32'(done), 32'd0);

        // Flush a DIVU at cycle N+10, then restart
        @(posedge clk);
        #1;
        funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        prev = result;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush done", 32'(done), 32'd0);
        check("flush result held", result, prev);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart busy", 32'(busy), 32'd1);
        wait_done("divu_after_flush", 32'd333, 33);

        // Asynchronous reset mid-MUL at cycle N+5
        @(posedge clk);
        #1;
        funct3 = 3'd0; op_a = 32'd5; op_b = 32'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst done", 32'(done), 32'd0);
        check("async rst stall", 32'(stall), 32'd0);
        check("async rst result", result, 32'd0);
        #1;
        rst = 1'b0;
        funct3 = 3'd3; op_a = 32'h8000_0000; op_b = 32'd4; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("post_rst accept busy", 32'(busy), 32'd1);
        wait_done("mulhu_after_rst", 32'd2, 33);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
